toggle_decoder: RTL and testbench
=================================

TOGGLE_DECODER -- requirements
Module: toggle_decoder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer depth on t_in (legal range 2..4).
REQ-002 SHALL have parameter PEND_W, default 4, giving the width of the pending-event counter.
REQ-003 SHALL have parameter CNT_W, default 8, giving the width of the total-event counter.
REQ-004 SHALL have parameter INIT_LVL, default 1'b0, giving the toggle level assumed at reset (matches a cleared remote tff).
REQ-005 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-006 SHALL have port clr  input  1  reset, asynchronous and active-low.
REQ-007 SHALL have port t_in  input  1  toggle level from the remote tff, asynchronous to clk.
REQ-008 SHALL have port evt_ready  input  1  consumer accepts one pending event.
REQ-009 SHALL have port ovf_clr  input  1  synchronous clear of the sticky overflow flag.
REQ-010 SHALL have port evt_pulse  output  1  one-cycle pulse per decoded toggle.
REQ-011 SHALL have port evt_valid  output  1  at least one un-accepted event is pending.
REQ-012 SHALL have port pend_cnt  output  PEND_W  number of pending events.
REQ-013 SHALL have port evt_total  output  CNT_W  count of all decoded toggles, wrapping modulo 2^CNT_W.
REQ-014 SHALL have port ovf  output  1  sticky flag: an event was lost to pending saturation.

Function
REQ-015 SHALL pass t_in through SYNC_STAGES flops, then compare the synchronized value with a reference-level register (ref).
REQ-016 SHALL decode a toggle when the synchronized value differs from ref, loading ref with the synchronized value in that same cycle.
REQ-017 SHALL assert evt_pulse, registered, for exactly one cycle per decoded toggle; the latency from a t_in edge to evt_pulse is SYNC_STAGES+1 cycles.
REQ-018 SHALL increment evt_total by 1 on each decoded toggle, wrapping from 2^CNT_W-1 to 0.
REQ-019 SHALL drive the pending FSM through the states EMPTY (pend_cnt=0), HOLD (0<pend_cnt<max) and FULL (pend_cnt=2^PEND_W-1).
REQ-020 SHALL make a handshake occur when evt_valid && evt_ready; each handshake decrements pend_cnt by 1.
REQ-021 SHALL hold evt_valid high exactly when the FSM is not in EMPTY; evt_ready in EMPTY has no effect.
REQ-022 SHALL increment pend_cnt by 1 on a decoded toggle with no handshake in that cycle.
REQ-023 SHALL leave pend_cnt unchanged when a decoded toggle and a handshake occur in the same cycle, including in FULL.
REQ-024 SHALL, on a decoded toggle in FULL with no handshake, leave pend_cnt at max and set ovf; evt_pulse and evt_total still update.
REQ-025 SHALL clear ovf on ovf_clr; if ovf_clr and a new overflow occur in the same cycle, ovf stays set.
REQ-026 SHALL decode reliably only when t_in edges are spaced at least SYNC_STAGES+1 cycles apart; closer edges may merge, which is accepted behaviour and not flagged.

Reset
REQ-027 SHALL, while clr is low, force all synchronizer stages and ref to INIT_LVL, pend_cnt, evt_total, ovf and evt_pulse to 0, and the FSM to EMPTY.
REQ-028 SHALL, on reset mid-operation, discard pending events; if t_in differs from INIT_LVL after release, exactly one event is decoded.

Configuration
REQ-029 SHALL, with macro TOGGLE_DEC_GLITCH_FILTER_EN defined, add one extra synchronized sample and decode a toggle only when the last two samples agree and differ from ref; latency becomes SYNC_STAGES+2 and a 1-cycle t_in glitch produces no event.
REQ-030 SHALL, without the macro, behave exactly as REQ-015..REQ-017.

Structure
REQ-031 SHALL take the FSM state enum and the default parameter constants from the shared package toggle_dec_pkg.
REQ-032 SHALL place the synchronizer in a sub-module toggle_sync (parameter SYNC_STAGES, asynchronous active-low clr, reset value INIT_LVL).

Verification
REQ-033 SHALL verify: reset release with t_in=0, then t_in 0->1 -> evt_pulse high on cycle 3 only, evt_total=1, pend_cnt=1, evt_valid=1.
REQ-034 SHALL verify: 3 toggles spaced 10 cycles apart, evt_ready held high -> 3 pulses, evt_total=3, pend_cnt returns to 0.
REQ-035 SHALL verify: PEND_W=4, evt_ready=0, 16 toggles -> pend_cnt=15 after the 15th, ovf=1 after the 16th, evt_total=16.
REQ-036 SHALL verify: pend_cnt=15 with a toggle and handshake in the same cycle -> pend_cnt stays 15, ovf stays 0.
REQ-037 SHALL verify: clr asserted with pend_cnt=5 and t_in=1, then released -> all outputs 0, then one event decoded, pend_cnt=1.
REQ-038 SHALL verify: with TOGGLE_DEC_GLITCH_FILTER_EN, a 1-cycle t_in pulse -> no evt_pulse and evt_total unchanged.

Source files
------------

// File: rtl/toggle_dec_pkg.sv
// ---------------------------------------------------------------------------
// toggle_dec_pkg
// Shared definitions for the toggle decoder:
//   - pend_state_e   : pending-event FSM states (EMPTY / HOLD / FULL)
//   - DEF_*          : default parameter constants for toggle_decoder
//   - pend_state_of  : maps a pending count onto its FSM state
// ---------------------------------------------------------------------------
package toggle_dec_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FULL  = 2'd2
    } pend_state_e;

    localparam int   DEF_SYNC_STAGES = 2;
    localparam int   DEF_PEND_W      = 4;
    localparam int   DEF_CNT_W       = 8;
    localparam logic DEF_INIT_LVL    = 1'b0;

    // Classify a pending count: zero is EMPTY, the saturation value is FULL.
    function automatic pend_state_e pend_state_of(input int unsigned cnt,
                                                  input int unsigned max_cnt);
        pend_state_e st;
        if (cnt == 32'd0) begin
            st = ST_EMPTY;
        end else if (cnt >= max_cnt) begin
            st = ST_FULL;
        end else begin
            st = ST_HOLD;
        end
        return st;
    endfunction

endpackage

// File: rtl/toggle_sync.sv
// ---------------------------------------------------------------------------
// toggle_sync
// Multi-flop synchronizer bringing the asynchronous toggle level into clk.
// Ports:
//   clk     : clock
//   clr     : asynchronous active-low reset, stages load INIT_LVL
//   i_t_in  : asynchronous toggle level
//   o_sync  : synchronized level (SYNC_STAGES cycles behind i_t_in)
// ---------------------------------------------------------------------------
module toggle_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic INIT_LVL    = 1'b0
) (
    input  logic clk,
    input  logic clr,
    input  logic i_t_in,
    output logic o_sync
);

    logic [SYNC_STAGES-1:0] r_sync;

    // Shift chain: bit 0 samples the raw input, the top bit is the output.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_sync <= {SYNC_STAGES{INIT_LVL}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_t_in};
        end
    end

    assign o_sync = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/toggle_decoder.sv
// ---------------------------------------------------------------------------
// toggle_decoder
// Turns level changes of a remote toggle flip-flop into one-cycle event
// pulses, counts them, and queues them for a ready-driven consumer.
// Ports:
//   clk        : clock, all state on rising edge
//   clr        : asynchronous active-low reset
//   t_in       : toggle level from the remote tff (asynchronous)
//   evt_ready  : consumer accepts one pending event when evt_valid is high
//   ovf_clr    : synchronous clear of the sticky overflow flag
//   evt_pulse  : registered one-cycle pulse per decoded toggle
//   evt_valid  : at least one pending event
//   pend_cnt   : number of pending events (saturates at 2^PEND_W-1)
//   evt_total  : total decoded toggles, wraps modulo 2^CNT_W
//   ovf        : sticky flag, an event was lost to pending saturation
// Build option:
//   TOGGLE_DEC_GLITCH_FILTER_EN : adds one extra sample and only decodes
//   when the last two samples agree (filters single-cycle glitches).
// ---------------------------------------------------------------------------
module toggle_decoder
    import toggle_dec_pkg::*;
#(
    parameter int   SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int   PEND_W      = DEF_PEND_W,
    parameter int   CNT_W       = DEF_CNT_W,
    parameter logic INIT_LVL    = DEF_INIT_LVL
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              t_in,
    input  logic              evt_ready,
    input  logic              ovf_clr,
    output logic              evt_pulse,
    output logic              evt_valid,
    output logic [PEND_W-1:0] pend_cnt,
    output logic [CNT_W-1:0]  evt_total,
    output logic              ovf
);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    logic              w_sync;
    logic              w_toggle;
    logic              w_hs;
    logic              w_ovf_set;
    logic [PEND_W-1:0] w_pend_nxt;
    pend_state_e       w_state_nxt;

    logic              r_ref;
    logic              r_pulse;
    logic              r_valid;
    logic              r_ovf;
    logic [PEND_W-1:0] r_pend;
    logic [CNT_W-1:0]  r_total;
    pend_state_e       r_state;

    toggle_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .INIT_LVL    (INIT_LVL)
    ) u_sync (
        .clk    (clk),
        .clr    (clr),
        .i_t_in (t_in),
        .o_sync (w_sync)
    );

`ifdef TOGGLE_DEC_GLITCH_FILTER_EN
    logic r_last;

    // One extra sample so a level must persist two cycles to count.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_last <= INIT_LVL;
        end else begin
            r_last <= w_sync;
        end
    end

    assign w_toggle = (w_sync == r_last) && (w_sync != r_ref);
`else
    assign w_toggle = (w_sync != r_ref);
`endif

    // A handshake can only happen while an event is actually pending.
    assign w_hs = r_valid & evt_ready;

    // Next pending count; a toggle in FULL without a handshake is lost.
    always_comb begin
        w_pend_nxt = r_pend;
        w_ovf_set  = 1'b0;
        if (w_toggle && !w_hs) begin
            if (r_state == ST_FULL) begin
                w_ovf_set = 1'b1;
            end else begin
                w_pend_nxt = r_pend + PEND_W'(1);
            end
        end else if (!w_toggle && w_hs) begin
            w_pend_nxt = r_pend - PEND_W'(1);
        end else begin
            w_pend_nxt = r_pend;
        end
        w_state_nxt = pend_state_of(32'(w_pend_nxt), 32'(PEND_MAX));
    end

    // Reference level follows the synchronized input on each decoded toggle.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_ref <= INIT_LVL;
        end else if (w_toggle) begin
            r_ref <= w_sync;
        end else begin
            r_ref <= r_ref;
        end
    end

    // Pending FSM with its registered outputs, event pulse, total and ovf.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= ST_EMPTY;
            r_valid <= 1'b0;
            r_pend  <= '0;
            r_pulse <= 1'b0;
            r_total <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pend  <= w_pend_nxt;
            case (w_state_nxt)
                ST_EMPTY: r_valid <= 1'b0;
                ST_HOLD:  r_valid <= 1'b1;
                ST_FULL:  r_valid <= 1'b1;
                default:  r_valid <= 1'b0;
            endcase
            r_pulse <= w_toggle;
            if (w_toggle) begin
                r_total <= r_total + CNT_W'(1);
            end else begin
                r_total <= r_total;
            end
            // A new overflow wins over a simultaneous clear.
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end else begin
                r_ovf <= r_ovf;
            end
        end
    end

    assign evt_pulse = r_pulse;
    assign evt_valid = r_valid;
    assign pend_cnt  = r_pend;
    assign evt_total = r_total;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_toggle_decoder.sv
// ---------------------------------------------------------------------------
// tb_toggle_decoder
// Directed bench for toggle_decoder with default parameters
// (SYNC_STAGES=2, PEND_W=4, CNT_W=8, INIT_LVL=0).
// ---------------------------------------------------------------------------
module tb_toggle_decoder;

`ifdef TOGGLE_DEC_GLITCH_FILTER_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic       clk;
    logic       clr;
    logic       t_in;
    logic       evt_ready;
    logic       ovf_clr;
    logic       evt_pulse;
    logic       evt_valid;
    logic [3:0] pend_cnt;
    logic [7:0] evt_total;
    logic       ovf;

    int n_tests;
    int n_fail;
    int pulses;

    toggle_decoder #(
        .SYNC_STAGES (2),
        .PEND_W      (4),
        .CNT_W       (8),
        .INIT_LVL    (1'b0)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .t_in      (t_in),
        .evt_ready (evt_ready),
        .ovf_clr   (ovf_clr),
        .evt_pulse (evt_pulse),
        .evt_valid (evt_valid),
        .pend_cnt  (pend_cnt),
        .evt_total (evt_total),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        t_in      = 1'b0;
        evt_ready = 1'b0;
        ovf_clr   = 1'b0;
        clr       = 1'b0;
        step(2);
        clr = 1'b1;
        step(3);
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        pulses    = 0;
        t_in      = 1'b0;
        evt_ready = 1'b0;
        ovf_clr   = 1'b0;
        clr       = 1'b0;
        step(3);

        // Reset state
        chk("rst_pulse", 32'(evt_pulse), 32'd0);
        chk("rst_valid", 32'(evt_valid), 32'd0);
        chk("rst_pend",  32'(pend_cnt),  32'd0);
        chk("rst_total", 32'(evt_total), 32'd0);
        chk("rst_ovf",   32'(ovf),       32'd0);
        clr = 1'b1;
        step(5);
        chk("idle_total", 32'(evt_total), 32'd0);

        // Single toggle: pulse appears exactly LAT cycles after the edge
        t_in = 1'b1;
        for (int k = 1; k < LAT; k++) begin
            step(1);
            chk("lat_early_pulse", 32'(evt_pulse), 32'd0);
        end
        step(1);
        chk("lat_pulse", 32'(evt_pulse), 32'd1);
        chk("lat_total", 32'(evt_total), 32'd1);
        chk("lat_pend",  32'(pend_cnt),  32'd1);
        chk("lat_valid", 32'(evt_valid), 32'd1);
        step(1);
        chk("lat_pulse_off", 32'(evt_pulse), 32'd0);

        // Three spaced toggles drained by a ready consumer
        do_reset();
        evt_ready = 1'b1;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            t_in = ~t_in;
            for (int k = 0; k < 10; k++) begin
                step(1);
                if (evt_pulse === 1'b1) pulses++;
            end
        end
        chk("drain_pulses", 32'(pulses),    32'd3);
        chk("drain_total",  32'(evt_total), 32'd3);
        chk("drain_pend",   32'(pend_cnt),  32'd0);
        chk("drain_valid",  32'(evt_valid), 32'd0);
        evt_ready = 1'b0;

        // Saturation: 16 toggles without a consumer
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            t_in = ~t_in;
            step(6);
            if (i == 15) begin
                chk("sat15_pend", 32'(pend_cnt), 32'd15);
                chk("sat15_ovf",  32'(ovf),      32'd0);
            end
        end
        chk("sat16_pend",  32'(pend_cnt),  32'd15);
        chk("sat16_ovf",   32'(ovf),       32'd1);
        chk("sat16_total", 32'(evt_total), 32'd16);
        chk("sat16_valid", 32'(evt_valid), 32'd1);

        // Sticky flag clear
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        chk("ovfclr_ovf", 32'(ovf), 32'd0);

        // Clear coinciding with a new overflow: overflow wins
        t_in = ~t_in;
        step(LAT - 1);
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        chk("ovfrace_pulse", 32'(evt_pulse), 32'd1);
        chk("ovfrace_ovf",   32'(ovf),       32'd1);
        chk("ovfrace_total", 32'(evt_total), 32'd17);
        step(3);

        // Toggle and handshake in the same cycle while FULL
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        chk("full_hs_preovf", 32'(ovf), 32'd0);
        t_in = ~t_in;
        step(LAT - 1);
        evt_ready = 1'b1;
        step(1);
        evt_ready = 1'b0;
        chk("full_hs_pulse", 32'(evt_pulse), 32'd1);
        chk("full_hs_pend",  32'(pend_cnt),  32'd15);
        chk("full_hs_ovf",   32'(ovf),       32'd0);
        chk("full_hs_total", 32'(evt_total), 32'd18);

        // Reset mid-operation with t_in high
        do_reset();
        for (int i = 0; i < 5; i++) begin
            t_in = ~t_in;
            step(6);
        end
        chk("mid_pend5", 32'(pend_cnt), 32'd5);
        clr = 1'b0;
        #1;
        chk("mid_rst_pend",  32'(pend_cnt),  32'd0);
        chk("mid_rst_total", 32'(evt_total), 32'd0);
        chk("mid_rst_valid", 32'(evt_valid), 32'd0);
        chk("mid_rst_ovf",   32'(ovf),       32'd0);
        chk("mid_rst_pulse", 32'(evt_pulse), 32'd0);
        step(2);
        clr = 1'b1;
        pulses = 0;
        for (int k = 1; k < LAT; k++) begin
            step(1);
            if (evt_pulse === 1'b1) pulses++;
        end
        chk("mid_early_pulses", 32'(pulses), 32'd0);
        step(1);
        chk("mid_pulse", 32'(evt_pulse), 32'd1);
        chk("mid_pend",  32'(pend_cnt),  32'd1);
        step(6);
        chk("mid_total_once", 32'(evt_total), 32'd1);
        chk("mid_pend_once",  32'(pend_cnt),  32'd1);

`ifdef TOGGLE_DEC_GLITCH_FILTER_EN
        // One-cycle glitch is filtered out
        do_reset();
        t_in = 1'b1;
        step(1);
        t_in = 1'b0;
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            step(1);
            if (evt_pulse === 1'b1) pulses++;
        end
        chk("glitch_pulses", 32'(pulses),    32'd0);
        chk("glitch_total",  32'(evt_total), 32'd0);
        chk("glitch_pend",   32'(pend_cnt),  32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
